// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare/bimodal branch predictor family.
package gshare_predictor_pkg;

  // Table index selection
  typedef enum logic {
    MODE_BIMODAL = 1'b0,
    MODE_GSHARE  = 1'b1
  } mode_e;

  // Weakly-not-taken starting value for a counter of width w: 2^(w-1)-1
  function automatic int unsigned ctr_init(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

  // Increment that sticks at max_v instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_stats.sv
// Three saturating statistics counters (branches, hits, misses) with a
// clear input that takes priority over counting in the same cycle.
module branch_stats
  import gshare_predictor_pkg::*;
#(
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  count,
  input  logic                  hit,
  output logic [STAT_WIDTH-1:0] total_branches,
  output logic [STAT_WIDTH-1:0] total_hits,
  output logic [STAT_WIDTH-1:0] total_misses
);

  localparam logic [31:0] STAT_MAX = 32'({STAT_WIDTH{1'b1}});

  logic [STAT_WIDTH-1:0] branches_q, branches_d;
  logic [STAT_WIDTH-1:0] hits_q, hits_d;
  logic [STAT_WIDTH-1:0] misses_q, misses_d;

  // Next-state: clear beats count; each counter saturates on its own
  always_comb begin
    branches_d = branches_q;
    hits_d     = hits_q;
    misses_d   = misses_q;
    if (clear) begin
      branches_d = '0;
      hits_d     = '0;
      misses_d   = '0;
    end else if (count) begin
      branches_d = STAT_WIDTH'(sat_inc(32'(branches_q), STAT_MAX));
      if (hit) begin
        hits_d = STAT_WIDTH'(sat_inc(32'(hits_q), STAT_MAX));
      end else begin
        misses_d = STAT_WIDTH'(sat_inc(32'(misses_q), STAT_MAX));
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branches_q <= '0;
      hits_q     <= '0;
      misses_q   <= '0;
    end else begin
      branches_q <= branches_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
    end
  end

  assign total_branches = branches_q;
  assign total_hits     = hits_q;
  assign total_misses   = misses_q;

endmodule

// File: rtl/gshare_predictor.sv
// Saturating-counter branch predictor with selectable bimodal or gshare
// indexing, global history register and on-chip accuracy statistics.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int HIST_WIDTH = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  enable,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] branch_address,
  input  logic                  branch_result,
  input  logic                  clear_stats,
  output logic                  prediction,
  output logic                  hit,
  output logic [STAT_WIDTH-1:0] total_branches,
  output logic [STAT_WIDTH-1:0] total_hits,
  output logic [STAT_WIDTH-1:0] total_misses
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_RESET = CTR_WIDTH'(ctr_init(CTR_WIDTH));
  localparam logic [31:0] CTR_MAX = 32'({CTR_WIDTH{1'b1}});

  // Counters are flops, not RAM: the whole table must reset asynchronously
  // and be read combinationally from pre-edge state.
  logic [CTR_WIDTH-1:0]  table_q [DEPTH];
  logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
  logic                  pred_q, pred_d;
  logic                  hit_q, hit_d;

  logic                  access;
  logic [ADDR_WIDTH-1:0] idx;
  logic [CTR_WIDTH-1:0]  ctr_rd, ctr_d;
  logic                  p;
  logic                  correct;

  assign access  = cs & enable;
  assign idx     = (mode == MODE_GSHARE) ? (branch_address ^ ADDR_WIDTH'(ghr_q))
                                         : branch_address;
  assign ctr_rd  = table_q[idx];
  assign p       = ctr_rd[CTR_WIDTH-1];
  assign correct = (p == branch_result);

  // Saturating up/down update of the selected counter
  always_comb begin
    ctr_d = ctr_rd;
    if (branch_result) begin
      ctr_d = CTR_WIDTH'(sat_inc(32'(ctr_rd), CTR_MAX));
    end else if (ctr_rd != '0) begin
      ctr_d = ctr_rd - CTR_WIDTH'(1);
    end
  end

  // History shift-in of the resolved outcome (width 1 has nothing to shift)
  generate
    if (HIST_WIDTH == 1) begin : g_ghr_one
      always_comb ghr_d = access ? branch_result : ghr_q;
    end else begin : g_ghr_many
      always_comb ghr_d = access ? {ghr_q[HIST_WIDTH-2:0], branch_result} : ghr_q;
    end
  endgenerate

  // Registered prediction/hit held until the next access
  always_comb begin
    pred_d = pred_q;
    hit_d  = hit_q;
    if (access) begin
      pred_d = p;
      hit_d  = correct;
    end
  end

  // One register per table entry; only the indexed entry is written
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          table_q[gi] <= CTR_RESET;
        end else if (access && (idx == ADDR_WIDTH'(gi))) begin
          table_q[gi] <= ctr_d;
        end
      end
    end
  endgenerate

  // History and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q  <= '0;
      pred_q <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      ghr_q  <= ghr_d;
      pred_q <= pred_d;
      hit_q  <= hit_d;
    end
  end

  assign prediction = pred_q;
  assign hit        = hit_q;

  branch_stats #(
    .STAT_WIDTH(STAT_WIDTH)
  ) u_stats (
    .clk           (clk),
    .rst           (rst),
    .clear         (cs & clear_stats),
    .count         (access),
    .hit           (correct),
    .total_branches(total_branches),
    .total_hits    (total_hits),
    .total_misses  (total_misses)
  );

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench: stimulus pushes hand-derived expectations, per-instance
// monitors pop and compare after every access edge.
module tb_gshare_predictor;

  typedef struct packed {
    logic        pred;
    logic        hit;
    logic        chk;
    logic [15:0] br;
    logic [15:0] h;
    logic [15:0] m;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_a = 1'b0;
  logic        cs_b = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  branch_address = 4'd0;
  logic        branch_result = 1'b0;
  logic        clear_stats = 1'b0;

  logic        pred_a, hit_a;
  logic [15:0] br_a, h_a, m_a;
  logic        pred_b, hit_b;
  logic [3:0]  br_b, h_b, m_b;

  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  gshare_predictor #(.ADDR_WIDTH(4), .HIST_WIDTH(4), .CTR_WIDTH(2), .STAT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .cs(cs_a), .enable(enable), .mode(mode),
    .branch_address(branch_address), .branch_result(branch_result),
    .clear_stats(clear_stats), .prediction(pred_a), .hit(hit_a),
    .total_branches(br_a), .total_hits(h_a), .total_misses(m_a)
  );

  gshare_predictor #(.ADDR_WIDTH(4), .HIST_WIDTH(4), .CTR_WIDTH(2), .STAT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .cs(cs_b), .enable(enable), .mode(mode),
    .branch_address(branch_address), .branch_result(branch_result),
    .clear_stats(clear_stats), .prediction(pred_b), .hit(hit_b),
    .total_branches(br_b), .total_hits(h_b), .total_misses(m_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic h, input logic c,
                              input int br, input int hh, input int mm);
    exp_t e;
    e.pred = p;
    e.hit  = h;
    e.chk  = c;
    e.br   = 16'(br);
    e.h    = 16'(hh);
    e.m    = 16'(mm);
    return e;
  endfunction

  task automatic acc(input bit b, input logic md, input logic [3:0] a, input logic r,
                     input logic clr, input exp_t e);
    @(negedge clk);
    cs_a           = !b;
    cs_b           = b;
    enable         = 1'b1;
    mode           = md;
    branch_address = a;
    branch_result  = r;
    clear_stats    = clr;
    if (b) qb.push_back(e);
    else   qa.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cs_a        = 1'b0;
    cs_b        = 1'b0;
    enable      = 1'b0;
    clear_stats = 1'b0;
  endtask

  // Monitor for the 16-bit-statistics instance
  always @(posedge clk) begin
    if (!rst && cs_a && enable) begin
      #1;
      if (qa.size() == 0) begin
        chk("a_queue_empty", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_pred", 32'(pred_a), 32'(ea.pred));
        chk("a_hit", 32'(hit_a), 32'(ea.hit));
        if (ea.chk) begin
          chk("a_branches", 32'(br_a), 32'(ea.br));
          chk("a_hits", 32'(h_a), 32'(ea.h));
          chk("a_misses", 32'(m_a), 32'(ea.m));
        end
        $display("txn A addr=%0d res=%0b pred=%0b hit=%0b br=%0d h=%0d m=%0d",
                 branch_address, branch_result, pred_a, hit_a, br_a, h_a, m_a);
      end
    end
  end

  // Monitor for the 4-bit-statistics instance
  always @(posedge clk) begin
    if (!rst && cs_b && enable) begin
      #1;
      if (qb.size() == 0) begin
        chk("b_queue_empty", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_pred", 32'(pred_b), 32'(eb.pred));
        chk("b_hit", 32'(hit_b), 32'(eb.hit));
        if (eb.chk) begin
          chk("b_branches", 32'(br_b), 32'(eb.br));
          chk("b_hits", 32'(h_b), 32'(eb.h));
          chk("b_misses", 32'(m_b), 32'(eb.m));
        end
        $display("txn B addr=%0d res=%0b pred=%0b hit=%0b br=%0d h=%0d m=%0d",
                 branch_address, branch_result, pred_b, hit_b, br_b, h_b, m_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_pred", 32'(pred_a), 32'd0);
    chk("rst_hit", 32'(hit_a), 32'd0);
    chk("rst_branches", 32'(br_a), 32'd0);
    chk("rst_hits", 32'(h_a), 32'd0);
    chk("rst_misses", 32'(m_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Bimodal training on addr 1: only the very first access misses
    for (int k = 1; k <= 1000; k++) begin
      if (k == 1) acc(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b1, 1, 0, 1));
      else        acc(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, k, k - 1, 1));
    end

    // Strongly taken survives one not-taken, then predicts taken again
    acc(1'b0, 1'b0, 4'd1, 1'b0, 1'b0, mk(1'b1, 1'b0, 1'b1, 1001, 999, 2));
    acc(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1002, 1000, 2));

    // Deselected: varied inputs for 10 edges must change nothing
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cs_a           = 1'b0;
      cs_b           = 1'b0;
      enable         = 1'b1;
      mode           = k[0];
      branch_address = 4'(k);
      branch_result  = k[1];
      clear_stats    = k[2];
    end
    @(negedge clk);
    enable      = 1'b0;
    clear_stats = 1'b0;
    chk("cs0_pred", 32'(pred_a), 32'd1);
    chk("cs0_hit", 32'(hit_a), 32'd1);
    chk("cs0_branches", 32'(br_a), 32'd1002);
    chk("cs0_hits", 32'(h_a), 32'd1000);
    chk("cs0_misses", 32'(m_a), 32'd2);
    acc(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 1003, 1001, 2));

    // Gshare on addr 0 with alternating T,N: history splits the two contexts
    idle();
    rst = 1'b1;
    #1;
    chk("rst2_pred", 32'(pred_a), 32'd0);
    chk("rst2_branches", 32'(br_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      logic r;
      r = (i % 2) == 1;
      if (i <= 6)       acc(1'b0, 1'b1, 4'd0, r, 1'b0, mk(1'b0, (i % 2) == 0, 1'b0, 0, 0, 0));
      else if (i == 64) acc(1'b0, 1'b1, 4'd0, r, 1'b0, mk(r, 1'b1, 1'b1, 64, 61, 3));
      else              acc(1'b0, 1'b1, 4'd0, r, 1'b0, mk(r, 1'b1, 1'b0, 0, 0, 0));
    end

    // 4-bit statistics saturate; then clear wins over a simultaneous access
    for (int k = 1; k <= 20; k++) begin
      acc(1'b1, 1'b0, 4'd3, 1'b1, 1'b0,
          mk(k >= 2, k >= 2, 1'b1, (k > 15) ? 15 : k, (k - 1 > 15) ? 15 : k - 1, 1));
    end
    acc(1'b1, 1'b0, 4'd3, 1'b1, 1'b1, mk(1'b1, 1'b1, 1'b1, 0, 0, 0));

    // Asynchronous reset in the middle of a run of accesses
    acc(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 65, 62, 3));
    acc(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 66, 63, 3));
    acc(1'b0, 1'b0, 4'd2, 1'b1, 1'b0, mk(1'b1, 1'b1, 1'b1, 67, 64, 3));
    #2;
    rst = 1'b1;
    #1;
    chk("async_pred", 32'(pred_a), 32'd0);
    chk("async_hit", 32'(hit_a), 32'd0);
    chk("async_branches", 32'(br_a), 32'd0);
    chk("async_hits", 32'(h_a), 32'd0);
    chk("async_misses", 32'(m_a), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b0;
    acc(1'b0, 1'b0, 4'd1, 1'b1, 1'b0, mk(1'b0, 1'b0, 1'b1, 1, 0, 1));

    idle();
    repeat (3) @(negedge clk);
    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
